light_ramp_scheduler: RTL and testbench



---
 rtl/light_ctrl_pkg.sv | 17 +
 rtl/light_ramp_scheduler_frame_tick_gen.sv | 33 +++
 rtl/light_ramp_scheduler.sv | 178 +++++++++++++++++
 tb/tb_light_ramp_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/light_ctrl_pkg.sv
// Shared types and default constants for the light ramp scheduler.
package light_ctrl_pkg;

  localparam int unsigned LEVEL_W_DEF       = 15;
  localparam int unsigned STEP_W_DEF        = 8;
  localparam int unsigned SETTLE_FRAMES_DEF = 2;
  localparam int unsigned SETTLE_CNT_W      = 4;
  localparam logic [14:0] MAX_LEVEL_DEF     = 15'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2,
    ST_SETTLE = 2'd3
  } ramp_state_e;

endpackage

// File: rtl/light_ramp_scheduler_frame_tick_gen.sv
// Frame tick generator: registered rising-edge detect on vsync, gated by enable.
// The vsync history resets high so a vsync already high at reset release gives no tick.
module frame_tick_gen (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  input  logic enable_i,
  output logic tick_o
);

  logic vsync_q;
  logic tick_q;
  logic tick_d;

  // Edge detect; ticks seen while disabled are dropped here, never queued.
  always_comb begin
    tick_d = vsync_i & ~vsync_q & enable_i;
  end

  // vsync history and one-cycle registered tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vsync_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/light_ramp_scheduler.sv
// Ramps the light level toward a handshaken target by one step per frame tick.
// Optional done interrupt: define LIGHT_RAMP_DONE_IRQ_EN.
module light_ramp_scheduler
  import light_ctrl_pkg::*;
#(
  parameter int unsigned          LEVEL_W       = LEVEL_W_DEF,
  parameter int unsigned          STEP_W        = STEP_W_DEF,
  parameter int unsigned          SETTLE_FRAMES = SETTLE_FRAMES_DEF,
  parameter logic [LEVEL_W-1:0]   MAX_LEVEL     = LEVEL_W'(MAX_LEVEL_DEF)
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_vsync,
  input  logic               I_enable,
  input  logic               I_tgt_valid,
  output logic               O_tgt_ready,
  input  logic [LEVEL_W-1:0] I_tgt_level,
  input  logic [STEP_W-1:0]  I_step,
  output logic [LEVEL_W-1:0] O_light_level,
  output logic               O_busy,
  output logic [1:0]         O_state
`ifdef LIGHT_RAMP_DONE_IRQ_EN
  ,
  input  logic               I_irq_clr,
  output logic               O_done_irq
`endif
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_FRAMES - 1);

  ramp_state_e               state_q, state_d;
  logic [LEVEL_W-1:0]        level_q, level_d;
  logic [LEVEL_W-1:0]        tgt_q, tgt_d;
  logic [STEP_W-1:0]         step_q, step_d;
  logic [SETTLE_CNT_W-1:0]   cnt_q, cnt_d;
  logic                      busy_q, busy_d;
  logic                      ready_q, ready_d;
  logic                      tick_s;
  logic [LEVEL_W-1:0]        tgt_clamp_s;
  logic [LEVEL_W:0]          sum_s;
  logic signed [LEVEL_W:0]   diff_s;

  frame_tick_gen u_tick (
    .clk_i    (I_clk),
    .rst_ni   (I_rst_n),
    .vsync_i  (I_vsync),
    .enable_i (I_enable),
    .tick_o   (tick_s)
  );

  // Arithmetic is one bit wider than the level so neither direction can wrap.
  always_comb begin
    tgt_clamp_s = (I_tgt_level > MAX_LEVEL) ? MAX_LEVEL : I_tgt_level;
    sum_s       = {1'b0, level_q} + {{(LEVEL_W + 1 - STEP_W){1'b0}}, step_q};
    diff_s      = $signed({1'b0, level_q}) - $signed({{(LEVEL_W + 1 - STEP_W){1'b0}}, step_q});
  end

  // Ramp FSM next-state; an accept in IDLE swallows any coincident tick.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (I_tgt_valid) begin
          tgt_d  = tgt_clamp_s;
          step_d = (I_step == {STEP_W{1'b0}}) ? STEP_W'(1) : I_step;
          if (tgt_clamp_s > level_q) begin
            state_d = ST_UP;
          end else if (tgt_clamp_s < level_q) begin
            state_d = ST_DOWN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UP: begin
        if (tick_s) begin
          if (sum_s >= {1'b0, tgt_q}) begin
            level_d = tgt_q;
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            level_d = sum_s[LEVEL_W-1:0];
          end
        end else begin
          level_d = level_q;
        end
      end
      ST_DOWN: begin
        if (tick_s) begin
          if (diff_s <= $signed({1'b0, tgt_q})) begin
            level_d = tgt_q;
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else begin
            level_d = diff_s[LEVEL_W-1:0];
          end
        end else begin
          level_d = level_q;
        end
      end
      ST_SETTLE: begin
        if (tick_s) begin
          if (cnt_q == {SETTLE_CNT_W{1'b0}}) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - SETTLE_CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= ST_IDLE;
      level_q <= {LEVEL_W{1'b0}};
      tgt_q   <= {LEVEL_W{1'b0}};
      step_q  <= STEP_W'(1);
      cnt_q   <= {SETTLE_CNT_W{1'b0}};
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign O_light_level = level_q;
  assign O_state       = state_q;
  assign O_busy        = busy_q;
  assign O_tgt_ready   = ready_q;

`ifdef LIGHT_RAMP_DONE_IRQ_EN
  logic done_irq_q, done_irq_d;

  // Sticky completion flag; a set in the same cycle as a clear wins.
  always_comb begin
    if ((state_q == ST_SETTLE) && (state_d == ST_IDLE)) begin
      done_irq_d = 1'b1;
    end else if (I_irq_clr) begin
      done_irq_d = 1'b0;
    end else begin
      done_irq_d = done_irq_q;
    end
  end

  // Done interrupt register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      done_irq_q <= 1'b0;
    end else begin
      done_irq_q <= done_irq_d;
    end
  end

  assign O_done_irq = done_irq_q;
`endif

endmodule

// File: tb/tb_light_ramp_scheduler.sv
// Bench for light_ramp_scheduler: directed table, hand sequences, random run vs. a model.
module tb_light_ramp_scheduler;

  localparam int MAXL = 32512;  // 15'h7F00
  localparam int SF   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync, en, valid, clr;
  logic [14:0] tgt_lvl;
  logic [7:0]  step;
  logic        ready, busy;
  logic [14:0] level;
  logic [1:0]  state;
`ifdef LIGHT_RAMP_DONE_IRQ_EN
  logic        done_irq;
`endif

  always #5 clk = ~clk;

  light_ramp_scheduler #(
    .LEVEL_W(15), .STEP_W(8), .SETTLE_FRAMES(SF), .MAX_LEVEL(15'h7F00)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_vsync(vsync), .I_enable(en),
    .I_tgt_valid(valid), .O_tgt_ready(ready), .I_tgt_level(tgt_lvl),
    .I_step(step), .O_light_level(level), .O_busy(busy), .O_state(state)
`ifdef LIGHT_RAMP_DONE_IRQ_EN
    , .I_irq_clr(clr), .O_done_irq(done_irq)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 rising, 2 falling, 3 settling.
  int m_level, m_tgt, m_step, m_mode, m_left;
  bit m_vs_prev, m_pend, m_irq;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_tgt = 0; m_step = 1; m_mode = 0; m_left = 0;
    m_vs_prev = 1'b1; m_pend = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_edge();
    bit consume, new_pend, set_irq;
    int t;
    consume   = m_pend;
    new_pend  = vsync && !m_vs_prev && en;
    m_vs_prev = vsync;
    set_irq   = 1'b0;
    case (m_mode)
      0: if (valid) begin
           t = (int'(tgt_lvl) > MAXL) ? MAXL : int'(tgt_lvl);
           m_tgt  = t;
           m_step = (step == 8'd0) ? 1 : int'(step);
           if (t > m_level) m_mode = 1;
           else if (t < m_level) m_mode = 2;
         end
      1: if (consume) begin
           m_level = (m_level + m_step < m_tgt) ? m_level + m_step : m_tgt;
           if (m_level == m_tgt) begin m_mode = 3; m_left = SF; end
         end
      2: if (consume) begin
           m_level = (m_level - m_step > m_tgt) ? m_level - m_step : m_tgt;
           if (m_level == m_tgt) begin m_mode = 3; m_left = SF; end
         end
      3: if (consume) begin
           m_left--;
           if (m_left == 0) begin m_mode = 0; set_irq = 1'b1; end
         end
      default: ;
    endcase
    if (set_irq) m_irq = 1'b1;
    else if (clr) m_irq = 1'b0;
    m_pend = new_pend;
  endtask

  task automatic check_all();
    check("level", int'(level), m_level);
    check("state", int'(state), m_mode);
    check("busy",  int'(busy),  int'(m_mode != 0));
    check("ready", int'(ready), int'(m_mode == 0));
`ifdef LIGHT_RAMP_DONE_IRQ_EN
    check("done_irq", int'(done_irq), int'(m_irq));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1; cycle();
    vsync = 1'b0; cycle(); cycle(); cycle();
  endtask

  task automatic accept(input int t, input int s);
    valid = 1'b1; tgt_lvl = 15'(t); step = 8'(s);
    cycle();
    valid = 1'b0; tgt_lvl = 15'h1234; step = 8'd77;
  endtask

  typedef struct {
    bit acc; int tgt; int stp; int nt; int exp_lvl; int exp_st;
  } vec_t;
  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 100,     30,  0,   0,      1};
    tbl[1]  = '{1'b0, 0,       0,   1,   30,     1};
    tbl[2]  = '{1'b0, 0,       0,   1,   60,     1};
    tbl[3]  = '{1'b0, 0,       0,   1,   90,     1};
    tbl[4]  = '{1'b0, 0,       0,   1,   100,    3};
    tbl[5]  = '{1'b0, 0,       0,   1,   100,    3};
    tbl[6]  = '{1'b0, 0,       0,   1,   100,    0};
    tbl[7]  = '{1'b1, 0,       0,   0,   100,    2};
    tbl[8]  = '{1'b0, 0,       0,   100, 0,      3};
    tbl[9]  = '{1'b0, 0,       0,   2,   0,      0};
    tbl[10] = '{1'b1, 'h7E50,  255, 0,   0,      1};
    tbl[11] = '{1'b0, 0,       0,   129, 'h7E50, 0};
    tbl[12] = '{1'b1, 'h7FFF,  255, 1,   'h7F00, 3};
    tbl[13] = '{1'b0, 0,       0,   2,   'h7F00, 0};
    tbl[14] = '{1'b1, 'h7FFF,  9,   0,   'h7F00, 0};

    vsync = 1'b1; en = 1'b1; valid = 1'b0; clr = 1'b0; tgt_lvl = 15'd0; step = 8'd0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // vsync already high at release must not tick.
    repeat (3) cycle();
    check("rst_level", int'(level), 0);
    check("rst_state", int'(state), 0);
    check("rst_ready", int'(ready), 1);
    vsync = 1'b0; cycle();

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].acc) accept(tbl[i].tgt, tbl[i].stp);
      for (int k = 0; k < tbl[i].nt; k++) vs_pulse();
      check($sformatf("tbl%0d_level", i), int'(level), tbl[i].exp_lvl);
      check($sformatf("tbl%0d_state", i), int'(state), tbl[i].exp_st);
    end

`ifdef LIGHT_RAMP_DONE_IRQ_EN
    check("irq_after_ramp", int'(done_irq), 1);
    clr = 1'b1; cycle(); clr = 1'b0;
    check("irq_cleared", int'(done_irq), 0);
    accept('h7F00, 5);
    repeat (3) cycle();
    check("irq_noop_accept", int'(done_irq), 0);
`endif

    // Tick arriving on the accept edge must not step.
    vsync = 1'b1; cycle();
    valid = 1'b1; tgt_lvl = 15'(MAXL - 50); step = 8'd20;
    cycle();
    valid = 1'b0; vsync = 1'b0;
    check("coinc_level", int'(level), MAXL);
    check("coinc_state", int'(state), 2);
    repeat (3) cycle();
    check("coinc_hold", int'(level), MAXL);
    vs_pulse();
    check("coinc_first_step", int'(level), MAXL - 20);

    // Disabled ticks are dropped; ramp resumes after re-enable.
    en = 1'b0;
    repeat (3) vs_pulse();
    check("dis_level", int'(level), MAXL - 20);
    check("dis_state", int'(state), 2);
    en = 1'b1;
    vs_pulse();
    check("reen_level", int'(level), MAXL - 40);

    // Asynchronous reset mid-ramp.
    @(negedge clk) rst_n = 1'b0;
    vsync = 1'b1;
    #1;
    model_reset();
    check("arst_level", int'(level), 0);
    check("arst_state", int'(state), 0);
    check("arst_ready", int'(ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) cycle();

    // Random traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 1) == 0) vsync = ~vsync;
      en    = ($urandom_range(0, 9) != 0);
      valid = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 7) == 0);
      step  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      case ($urandom_range(0, 5))
        0:       tgt_lvl = 15'h7FFF;
        1:       tgt_lvl = 15'(m_level);
        2:       tgt_lvl = 15'($urandom_range(0, 600));
        default: tgt_lvl = 15'($urandom_range(0, 32767));
      endcase
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
